i2s_adc_rx: RTL and testbench
=============================

Name: i2s_adc_rx

Overview:
- Receives the codec's I2S capture stream (BCLK, ADCLRCK, ADCDAT) in the system clock domain.
- Deserialises left and right words and pairs them into stereo frames.
- Buffers frames in a small FIFO and presents them on a valid/ready stream to the downstream mic-array processing.
- Sits directly downstream of the audio codec external interface pins, on the capture path.

Parameters:
- DATA_WIDTH, 24, bits captured per channel, MSB first.
- SLOT_WIDTH, 32, BCLK periods per LRCK half-period. Must satisfy SLOT_WIDTH >= DATA_WIDTH+1.
- FIFO_DEPTH, 4, stereo frames buffered. Power of two, >= 2.

Ports:
- clk_clk  in  1  system clock. Must be >= 4x BCLK frequency.
- reset_reset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable.
- aud_bclk  in  1  codec bit clock (asynchronous).
- aud_adclrck  in  1  codec ADC LR clock: 0 = left, 1 = right.
- aud_adcdat  in  1  codec ADC serial data.
- left_data  out  DATA_WIDTH  FIFO head, left sample.
- right_data  out  DATA_WIDTH  FIFO head, right sample.
- valid  out  1  FIFO head holds a frame.
- ready  in  1  consumer accepts the head.
- fill_level  out  clog2(FIFO_DEPTH+1)  frames currently stored.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- clear_overflow  in  1  clears overflow.
- frame_err  out  1  one-cycle pulse on a short word.

Behaviour:
- Reset: all outputs 0; FIFO emptied; state SYNC; synchroniser and shift registers cleared. Reset mid-frame discards the partial frame.
- Input sampling:
  - The three codec inputs pass through 2-FF synchronisers; bclk also gets a third delay stage.
  - A BCLK rise is detected as s2 & ~s3, i.e. one clk_clk cycle per BCLK rise.
  - On each detected rise, the synchronised lrck and dat are sampled together.
- Bit counter (cnt):
  - Boundary: on a rise whose sampled lrck differs from the previous sampled lrck, cnt <= 0 and the data bit is ignored (I2S one-bit delay).
  - On subsequent rises, cnt increments up to a saturation value of DATA_WIDTH+1.
  - Rises at cnt 1..DATA_WIDTH shift the data bit into the channel shift register, MSB first.
  - Bits beyond DATA_WIDTH are ignored.
  - The word is complete on the rise at which cnt reaches DATA_WIDTH.
- FSM states SYNC, LEFT, RIGHT:
  - SYNC -> LEFT: on a boundary to lrck=0. Words before that are discarded, so start-up inside a right slot never pushes.
  - LEFT: on completion, hold the left word. On a boundary to lrck=1 -> RIGHT.
  - RIGHT: on completion, push {left, right} to the FIFO in the same clk_clk cycle. On a boundary to lrck=0 -> LEFT.
  - Short word: a boundary arriving before completion pulses frame_err for 1 cycle, drops the partial frame, and returns to SYNC. It re-enters LEFT on that same boundary if the new lrck=0.
  - enable=0: FSM forced to SYNC, no pushes. FIFO still drains normally.
- FIFO:
  - First-word-fall-through, circular pointers wrap modulo FIFO_DEPTH.
  - Pop occurs when valid & ready.
  - Push when full and no pop in the same cycle: new frame dropped, overflow <= 1.
  - Push and pop in the same cycle when full: both proceed, fill_level unchanged, no overflow.
  - Push and pop in the same cycle when empty: not possible, because valid is registered.
  - clear_overflow clears the flag; an overflow event in the same cycle wins (flag stays 1).
- Outputs:
  - left_data/right_data show the FIFO head when valid=1, and 0 when valid=0.
  - valid = (fill_level != 0), registered.
  - Latency: with an empty FIFO, valid rises 4 clk_clk cycles after the cycle in which synchroniser stage 1 first captures the BCLK high that carries the right LSB.

Test Plan:
- Reset: assert reset_reset during traffic -> next cycle all outputs 0, fill_level 0; partial frame never appears.
- Single frame: BCLK = clk/8, L=0xA5A5A5, R=0x5A5A5A, ready=0 -> valid=1, left_data=0xA5A5A5, right_data=0x5A5A5A, fill_level=1; one ready cycle -> valid=0, data 0.
- Start-up mid-right: stream begins at right bit 10 -> partial right discarded; first popped frame is the first complete L/R pair; frame_err stays 0.
- Overflow: ready=0, 5 frames (FIFO_DEPTH=4) -> fill_level=4, overflow=1 after frame 5; clear_overflow -> 0; draining returns frames 1..4 in order.
- Short word: lrck toggles after 16 left bits -> one frame_err pulse, no push; following full L/R pair pushed normally.
- Full + simultaneous push/pop: FIFO full, ready=1 in the push cycle -> fill_level stays 4, overflow=0, order preserved. Then enable=0 mid-stream -> no further pushes, FIFO drains to 0.

Source files
------------

// File: rtl/i2s_adc_rx.sv
// -----------------------------------------------------------------------------
// i2s_adc_rx
//
// Captures the codec's I2S ADC stream (BCLK / ADCLRCK / ADCDAT) in the system
// clock domain, deserialises left and right words, pairs them into stereo
// frames and buffers them in a small first-word-fall-through FIFO. The FIFO
// head is presented on a valid/ready stream.
//
// Ports:
//   clk_clk         system clock (at least 4x BCLK)
//   reset_reset     synchronous, active-high reset
//   enable          capture enable; 0 holds the framer in SYNC, FIFO still drains
//   aud_bclk        codec bit clock (asynchronous)
//   aud_adclrck     codec LR clock: 0 = left slot, 1 = right slot (asynchronous)
//   aud_adcdat      codec serial data, MSB first (asynchronous)
//   left_data       FIFO head, left sample (0 when valid = 0)
//   right_data      FIFO head, right sample (0 when valid = 0)
//   valid           FIFO head holds a frame
//   ready           consumer accepts the head
//   fill_level      frames currently stored
//   overflow        sticky: a frame was dropped because the FIFO was full
//   clear_overflow  clears overflow (a same-cycle drop keeps it set)
//   frame_err       one-cycle pulse when a word is cut short by an LR edge
//
// Handshake: a frame transfers on every clk_clk rising edge where
// valid & ready are both 1. valid never drops while a frame is waiting, and the
// head data is stable until it has been accepted.
//
// Pipeline (BCLK rise to FIFO write): sync stage 1, sync stage 2 / edge detect,
// sample register, bit/word logic + frame register, FIFO write. With an empty
// FIFO, valid rises 4 clk_clk cycles after stage 1 captures the BCLK high that
// carries the right-channel LSB.
// -----------------------------------------------------------------------------
module i2s_adc_rx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk_clk,
    input  logic                                  reset_reset,
    input  logic                                  enable,
    input  logic                                  aud_bclk,
    input  logic                                  aud_adclrck,
    input  logic                                  aud_adcdat,
    output logic [DATA_WIDTH-1:0]                 left_data,
    output logic [DATA_WIDTH-1:0]                 right_data,
    output logic                                  valid,
    input  logic                                  ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fill_level,
    output logic                                  overflow,
    input  logic                                  clear_overflow,
    output logic                                  frame_err
);

    localparam int CW = $clog2(DATA_WIDTH + 2);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = 2 * DATA_WIDTH;

    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_WIDTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    // Elaboration-time parameter sanity checks.
    if (SLOT_WIDTH < DATA_WIDTH + 1) begin : g_bad_slot
        $error("i2s_adc_rx: SLOT_WIDTH must be at least DATA_WIDTH+1");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("i2s_adc_rx: FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronisers. bclk gets a third stage so a rise can be seen as
    // s2 & ~s3; lrck/dat stage 2 lines up with bclk stage 2.
    // -------------------------------------------------------------------------
    logic bclk_s1, bclk_s2, bclk_s3;
    logic lrck_s1, lrck_s2;
    logic dat_s1,  dat_s2;
    logic rise;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            dat_s1  <= 1'b0;
            dat_s2  <= 1'b0;
        end else begin
            bclk_s1 <= aud_bclk;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            lrck_s1 <= aud_adclrck;
            lrck_s2 <= lrck_s1;
            dat_s1  <= aud_adcdat;
            dat_s2  <= dat_s1;
        end
    end

    assign rise = bclk_s2 & ~bclk_s3;

    // Sample register: lrck and dat captured together on each BCLK rise.
    logic smp_valid, smp_lrck, smp_dat;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            smp_valid <= 1'b0;
            smp_lrck  <= 1'b0;
            smp_dat   <= 1'b0;
        end else begin
            smp_valid <= rise;
            smp_lrck  <= lrck_s2;
            smp_dat   <= dat_s2;
        end
    end

    // -------------------------------------------------------------------------
    // Bit counter and shift register.
    // cnt = 0 on the boundary rise (I2S one-bit delay, data ignored), then
    // counts up and saturates at DATA_WIDTH+1 so trailing slot bits are ignored.
    // sh holds the upper DATA_WIDTH-1 bits; the incoming bit completes the word.
    // -------------------------------------------------------------------------
    logic                  prev_lrck;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-2:0] sh;
    logic [DATA_WIDTH-1:0] word;
    logic                  boundary;
    logic                  shifting;
    logic                  word_done;
    logic                  short_word;

    always_comb begin
        boundary   = smp_valid && (smp_lrck != prev_lrck);
        shifting   = smp_valid && !boundary && (cnt < CNT_FULL);
        word       = {sh, smp_dat};
        word_done  = shifting && (cnt == CNT_LAST);
        // An LR edge before the previous slot's word completed.
        short_word = boundary && (cnt < CNT_FULL);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            prev_lrck <= 1'b0;
            cnt       <= '0;
            sh        <= '0;
        end else if (smp_valid) begin
            prev_lrck <= smp_lrck;
            if (boundary) begin
                cnt <= '0;
                sh  <= '0;
            end else begin
                if (cnt != CNT_SAT) begin
                    cnt <= cnt + CW'(1);
                end
                if (shifting) begin
                    sh <= word[DATA_WIDTH-2:0];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Framing FSM.
    // -------------------------------------------------------------------------
    state_t                state, state_next;
    logic                  hold_left;
    logic                  push_next;
    logic                  err_next;
    logic [DATA_WIDTH-1:0] left_hold;
    logic                  push_req;
    logic [FW-1:0]         push_frame;

    always_comb begin
        state_next = state;
        hold_left  = 1'b0;
        push_next  = 1'b0;
        err_next   = 1'b0;
        if (!enable) begin
            state_next = SYNC;
        end else begin
            unique case (state)
                SYNC: begin
                    if (boundary && !smp_lrck) begin
                        state_next = LEFT;
                    end
                end
                LEFT: begin
                    hold_left = word_done;
                    if (boundary) begin
                        if (short_word) begin
                            err_next   = 1'b1;
                            state_next = smp_lrck ? SYNC : LEFT;
                        end else begin
                            state_next = smp_lrck ? RIGHT : LEFT;
                        end
                    end
                end
                RIGHT: begin
                    push_next = word_done;
                    if (boundary) begin
                        // A short right word drops the frame; the same edge
                        // starts a new left slot when lrck went to 0.
                        if (short_word) begin
                            err_next = 1'b1;
                        end
                        state_next = smp_lrck ? SYNC : LEFT;
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= SYNC;
            left_hold  <= '0;
            push_req   <= 1'b0;
            push_frame <= '0;
            frame_err  <= 1'b0;
        end else begin
            state     <= state_next;
            push_req  <= push_next;
            frame_err <= err_next;
            if (hold_left) begin
                left_hold <= word;
            end
            if (push_next) begin
                push_frame <= {left_hold, word};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame FIFO (first-word-fall-through). A push into a full FIFO is accepted
    // when the head is popped in the same cycle; otherwise it is dropped.
    // -------------------------------------------------------------------------
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count, count_next;
    logic          pop, full, push_ok, drop;

    always_comb begin
        pop     = valid && ready;
        full    = (count == LVL_FULL);
        push_ok = push_req && (!full || pop);
        drop    = push_req && full && !pop;
        unique case ({push_ok, pop})
            2'b10:   count_next = count + LW'(1);
            2'b01:   count_next = count - LW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_frame;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            valid <= (count_next != '0);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign fill_level = count;
    assign left_data  = valid ? mem[rd_ptr][FW-1:DATA_WIDTH] : '0;
    assign right_data = valid ? mem[rd_ptr][DATA_WIDTH-1:0]  : '0;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_adc_rx
//
// Directed sequence with randomised sample words and filler bits. The codec is
// modelled as whole I2S slots (one junk bit, DATA_WIDTH data bits MSB first,
// junk to the slot end) with BCLK = clk/8. The reference model is a queue of
// expected stereo frames plus an expected overflow flag, updated per frame from
// the FIFO rules; a negedge monitor compares every accepted head frame.
// -----------------------------------------------------------------------------
module tb_i2s_adc_rx;

    localparam int DW    = 24;
    localparam int SW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic          enable;
    logic          aud_bclk;
    logic          aud_adclrck;
    logic          aud_adcdat;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          valid;
    logic          ready;
    logic [LW-1:0] fill_level;
    logic          overflow;
    logic          clear_overflow;
    logic          frame_err;

    i2s_adc_rx #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .enable         (enable),
        .aud_bclk       (aud_bclk),
        .aud_adclrck    (aud_adclrck),
        .aud_adcdat     (aud_adcdat),
        .left_data      (left_data),
        .right_data     (right_data),
        .valid          (valid),
        .ready          (ready),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .frame_err      (frame_err)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk_clk = ~clk_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------- scoreboard
    int             checks = 0;
    int             errors = 0;
    int             err_pulses = 0;
    logic [2*DW-1:0] exp_q[$];
    logic           exp_overflow = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepted frames are compared against the head of the expected queue.
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (frame_err === 1'b1) err_pulses++;
            if (valid === 1'b1 && ready === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL pop_unexpected: observed frame %0h expected no frame",
                           {left_data, right_data});
                end
                if (exp_q.size() != 0) begin
                    logic [2*DW-1:0] e;
                    e = exp_q.pop_front();
                    check("pop_frame", 64'({left_data, right_data}), 64'(e));
                end
            end
        end
    end

    // Frame model: a completed pair enters the FIFO unless it is full with no
    // simultaneous pop, in which case it is dropped and overflow is set.
    task automatic model_push(input logic [2*DW-1:0] f, input bit pop_same);
        if (enable) begin
            if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(f);
            else exp_overflow = 1'b1;
        end
    endtask

    // -------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic bit_period(input logic lr, input logic d);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_adcdat  = d;
        repeat (4) tick();
        aud_bclk = 1'b1;
        repeat (4) tick();
    endtask

    // One ready cycle timed to the edge at which the right LSB frame is written.
    task automatic ready_pulse();
        repeat (8) tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic send_slot(input logic lr, input logic [DW-1:0] w,
                             input int first, input int last, input bit pop_at_lsb);
        logic d;
        for (int p = first; p <= last; p++) begin
            d = 1'($urandom_range(0, 1));
            if (p >= 1 && p <= DW) d = w[DW-p];
            if (p == DW && pop_at_lsb) begin
                fork
                    ready_pulse();
                join_none
            end
            bit_period(lr, d);
        end
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit pop_at_lsb);
        send_slot(1'b0, l, 0, SW-1, 1'b0);
        model_push({l, r}, pop_at_lsb);
        send_slot(1'b1, r, 0, SW-1, pop_at_lsb);
    endtask

    task automatic send_rand_pair(input bit pop_at_lsb);
        send_pair(DW'($urandom), DW'($urandom), pop_at_lsb);
    endtask

    task automatic pop_one();
        check("pop_valid", 64'(valid), 64'(1));
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"},     64'(valid),      64'(0));
        check({tag, "_left"},      64'(left_data),  64'(0));
        check({tag, "_right"},     64'(right_data), 64'(0));
        check({tag, "_fill"},      64'(fill_level), 64'(0));
        check({tag, "_overflow"},  64'(overflow),   64'(0));
        check({tag, "_frame_err"}, 64'(frame_err),  64'(0));
    endtask

    // ------------------------------------------------------------- sequence
    int base;

    initial begin
        reset_reset    = 1'b1;
        enable         = 1'b1;
        aud_bclk       = 1'b0;
        aud_adclrck    = 1'b0;
        aud_adcdat     = 1'b0;
        ready          = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset_reset = 1'b0;
        tick();

        // Start-up inside a right slot, then one known frame.
        send_slot(1'b1, DW'($urandom), 10, SW-1, 1'b0);
        send_pair(24'hA5A5A5, 24'h5A5A5A, 1'b0);
        check("single_valid", 64'(valid),      64'(1));
        check("single_left",  64'(left_data),  64'(24'hA5A5A5));
        check("single_right", 64'(right_data), 64'(24'h5A5A5A));
        check("single_fill",  64'(fill_level), 64'(1));
        check("startup_err",  64'(err_pulses), 64'(0));
        pop_one();
        check("after_pop_valid", 64'(valid),      64'(0));
        check("after_pop_left",  64'(left_data),  64'(0));
        check("after_pop_right", 64'(right_data), 64'(0));
        check("after_pop_fill",  64'(fill_level), 64'(0));

        // Overflow: five frames into a four-deep FIFO with ready low.
        for (int i = 0; i < 5; i++) begin
            send_rand_pair(1'b0);
            check("ovf_fill", 64'(fill_level), 64'(exp_q.size()));
            check("ovf_flag", 64'(overflow),   64'(exp_overflow));
        end
        check("ovf_set", 64'(overflow), 64'(1));
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        exp_overflow   = 1'b0;
        check("ovf_clear", 64'(overflow), 64'(exp_overflow));
        repeat (DEPTH) pop_one();
        check("ovf_drained", 64'(fill_level), 64'(0));

        // Short word: lrck toggles after 16 left bits.
        base = err_pulses;
        send_slot(1'b0, DW'($urandom), 0, 16, 1'b0);
        send_slot(1'b1, DW'($urandom), 0, SW-1, 1'b0);
        check("short_err_pulse", 64'(err_pulses - base), 64'(1));
        check("short_no_push",   64'(fill_level),        64'(0));
        send_rand_pair(1'b0);
        check("short_recover_fill", 64'(fill_level),        64'(1));
        check("short_single_pulse", 64'(err_pulses - base), 64'(1));
        pop_one();

        // Full FIFO with a pop in the push cycle.
        for (int i = 0; i < DEPTH; i++) send_rand_pair(1'b0);
        check("full_fill", 64'(fill_level), 64'(DEPTH));
        send_rand_pair(1'b1);
        check("pushpop_fill",     64'(fill_level), 64'(DEPTH));
        check("pushpop_overflow", 64'(overflow),   64'(0));
        repeat (DEPTH) pop_one();
        check("pushpop_drained", 64'(fill_level), 64'(0));

        // enable dropped mid-stream: no further pushes, FIFO drains.
        send_rand_pair(1'b0);
        send_rand_pair(1'b0);
        send_slot(1'b0, DW'($urandom), 0, 12, 1'b0);
        enable = 1'b0;
        send_slot(1'b0, DW'($urandom), 13, SW-1, 1'b0);
        send_slot(1'b1, DW'($urandom), 0, SW-1, 1'b0);
        send_rand_pair(1'b0);
        send_rand_pair(1'b0);
        check("disable_fill",     64'(fill_level), 64'(2));
        check("disable_overflow", 64'(overflow),   64'(0));
        repeat (2) pop_one();
        check("disable_drained_fill",  64'(fill_level), 64'(0));
        check("disable_drained_valid", 64'(valid),      64'(0));
        enable = 1'b1;

        // Reset mid-frame with a frame already buffered.
        send_rand_pair(1'b0);
        check("prereset_fill", 64'(fill_level), 64'(1));
        send_slot(1'b0, DW'($urandom), 0, SW-1, 1'b0);
        send_slot(1'b1, DW'($urandom), 0, 10, 1'b0);
        reset_reset = 1'b1;
        tick();
        check_idle_outputs("midreset");
        reset_reset = 1'b0;
        exp_q.delete();
        exp_overflow = 1'b0;
        send_slot(1'b1, DW'($urandom), 11, SW-1, 1'b0);
        send_rand_pair(1'b0);
        check("postreset_fill", 64'(fill_level), 64'(1));
        pop_one();
        check("postreset_drained", 64'(fill_level), 64'(0));
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
